crc_parallel: RTL and testbench
===============================

// Module: crc_parallel
// PURPOSE
//  Parametrised CRC engine consuming DATA_W bits per clock instead of one serial bit.
//  Handles framed input with a valid/ready handshake and returns one CRC per frame.
//  Sits after a packet source or width converter; next generation of crc_static.
// PARAMETERS
//  CRC_SIZE   32             CRC width in bits (8..64)
//  DATA_W     8              input bits per beat (1..64; multiple of 8 if CRC_REFLECT_EN)
//  INIT       32'h0          seed loaded at first beat of every frame
//  POLY       32'h04C11DB7   generator polynomial, implicit x^CRC_SIZE term
//  FINAL_XOR  32'hFFFFFFFF   XOR applied to register when presenting crc_out
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-low
//  in_valid   in   1          input beat valid
//  in_ready   out  1          engine can accept a beat
//  in_data    in   DATA_W     beat data, MSB processed first
//  in_last    in   1          marks final beat of frame
//  crc_valid  out  1          crc_out holds a finished frame CRC
//  crc_ready  in   1          consumer accepts crc_out
//  crc_out    out  CRC_SIZE   final CRC = reg ^ FINAL_XOR
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, crc reg=INIT, in_ready=1, crc_valid=0, crc_out=0.
//  - FSM: IDLE -(beat accepted, !in_last)-> RUN; IDLE -(beat, in_last)-> DONE;
//    RUN -(beat, in_last)-> DONE; DONE -(crc_ready)-> IDLE.
//  - Beat accepted when in_valid & in_ready. in_ready = (state != DONE).
//  - Accepted beat in IDLE: reg <= step(INIT, in_data); in RUN: reg <= step(reg, in_data).
//  - step = DATA_W unrolled shift/XOR iterations, one full beat per clock, no bubbles.
//  - Latency: crc_valid rises the cycle after the last beat is accepted (1 clock).
//  - crc_out registered; stable while crc_valid=1; cleared to 0 on leaving DONE.
//  - DONE with crc_valid=1 & crc_ready=0: hold indefinitely, in_ready=0 (backpressure).
//  - crc_ready & in_valid same cycle in DONE: result handed off, beat NOT accepted;
//    beat accepted next cycle from IDLE as first beat of new frame.
//  - Single-beat frame (in_valid & in_last from IDLE) legal; zero-length frame unsupported.
//  - in_data/in_last ignored when in_valid=0; crc_ready ignored outside DONE.
//  - Async reset mid-frame discards partial CRC; no output produced for that frame.
//  - Parameters wider than CRC_SIZE are truncated to CRC_SIZE LSBs.
// CONFIGURATION
//  CRC_REFLECT_EN defined: each input byte processed LSB-first (bytes still MSB-byte
//    first); register bit-reversed across CRC_SIZE before FINAL_XOR on crc_out.
//  CRC_REFLECT_EN undefined: bits processed MSB-first, no output reflection.
// STRUCTURE
//  - Package crc_pkg: FSM state encoding (IDLE, RUN, DONE), reflect function,
//    standard polynomial constants (CRC32 04C11DB7, CRC16_CCITT 1021, CRC8 07).
//  - Sub-module crc_step: combinational next-CRC of (crc, data), params CRC_SIZE,
//    DATA_W, POLY; reusable by crc_static/crc_dynamic successors.
//  - Top holds FSM, crc register, output register and handshake logic.
// TESTING
//  1. No reflect, INIT=FFFFFFFF, FINAL_XOR=0, DATA_W=8, "123456789" back-to-back
//     -> crc_out=32'h0376E6E7, crc_valid exactly 1 clock after last beat.
//  2. CRC_REFLECT_EN, INIT=FFFFFFFF, FINAL_XOR=FFFFFFFF, "123456789"
//     -> crc_out=32'hCBF43926.
//  3. CRC_SIZE=16, POLY=1021, INIT=FFFF, FINAL_XOR=0, DATA_W=32, beats 31323334,
//     35363738, 39 padded? no: use DATA_W=8 "123456789" -> crc_out=16'h29B1.
//  4. Hold crc_ready=0 for 10 clocks after frame with in_valid=1 -> in_ready=0,
//     crc_out stable; crc_ready=1 -> next frame starts from INIT, same CRC repeated.
//  5. Random in_valid gaps during frame of test 1 -> crc_out still 32'h0376E6E7.
//  6. Assert rst=0 mid-frame (after beat 4) -> outputs at reset values immediately;
//     full new frame afterwards -> 32'h0376E6E7.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM encoding, standard polynomials and bit-reflection helper
// for the CRC engine family.
package crc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [63:0] CRC32_POLY       = 64'h04C11DB7;
    localparam logic [63:0] CRC16_CCITT_POLY = 64'h1021;
    localparam logic [63:0] CRC8_POLY        = 64'h07;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [63:0] reflect(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < w) r[i] = v[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: combinational next-CRC for one DATA_W-bit beat, data MSB first,
// unrolled into DATA_W shift/XOR stages.
module crc_step #(
    parameter int          CRC_SIZE = 32,
    parameter int          DATA_W   = 8,
    parameter logic [63:0] POLY     = 64'h04C11DB7
) (
    input  logic [CRC_SIZE-1:0] crc,
    input  logic [DATA_W-1:0]   data,
    output logic [CRC_SIZE-1:0] nxt
);

    localparam logic [CRC_SIZE-1:0] P = POLY[CRC_SIZE-1:0];

    always_comb begin
        logic [CRC_SIZE-1:0] c;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--)
            c = {c[CRC_SIZE-2:0], 1'b0} ^ ((c[CRC_SIZE-1] ^ data[i]) ? P : '0);
        nxt = c;
    end

endmodule

// File: rtl/crc_parallel.sv
// crc_parallel: framed valid/ready CRC engine, one DATA_W beat per clock.
// Define CRC_REFLECT_EN for LSB-first bytes and a reflected result.
module crc_parallel
    import crc_pkg::*;
#(
    parameter int          CRC_SIZE  = 32,
    parameter int          DATA_W    = 8,
    parameter logic [63:0] INIT      = 64'h0,
    parameter logic [63:0] POLY      = 64'h04C11DB7,
    parameter logic [63:0] FINAL_XOR = 64'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [CRC_SIZE-1:0] crc_out
);

    localparam logic [CRC_SIZE-1:0] SEED = INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] XOR  = FINAL_XOR[CRC_SIZE-1:0];

    state_t              state, state_nxt;
    logic [CRC_SIZE-1:0] crc_q, crc_in, crc_nxt, crc_fin;
    logic [DATA_W-1:0]   data;
    logic                accept;

    assign in_ready  = state != DONE;
    assign crc_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign crc_in    = (state == IDLE) ? SEED : crc_q;

`ifdef CRC_REFLECT_EN
    // Bit order flips inside each byte; byte order stays MSB-byte first.
    always_comb begin
        data = '0;
        for (int i = 0; i < DATA_W; i++)
            data[i] = in_data[(i / 8) * 8 + 7 - i % 8];
    end
    assign crc_fin = CRC_SIZE'(reflect(64'(crc_nxt), CRC_SIZE)) ^ XOR;
`else
    assign data    = in_data;
    assign crc_fin = crc_nxt ^ XOR;
`endif

    crc_step #(.CRC_SIZE(CRC_SIZE), .DATA_W(DATA_W), .POLY(POLY)) u_step (
        .crc (crc_in),
        .data(data),
        .nxt (crc_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (state == DONE) state_nxt = crc_ready ? IDLE : DONE;
        else if (accept) state_nxt = in_last ? DONE : RUN;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            crc_q   <= SEED;
            crc_out <= '0;
        end else begin
            if (accept) crc_q <= crc_nxt;
            if (accept && in_last) crc_out <= crc_fin;
            else if (state == DONE && crc_ready) crc_out <= '0;
        end

endmodule

// File: tb/tb_crc_parallel.sv
// tb_crc_parallel: directed checks of a CRC-32 and a CRC-16 instance fed the
// same "123456789" frames; expectations follow the CRC_REFLECT_EN build.
module tb_crc_parallel;

`ifdef CRC_REFLECT_EN
    localparam logic [63:0] FX32 = 64'hFFFFFFFF;
    localparam logic [31:0] E32  = 32'hCBF43926;
    localparam logic [15:0] E16  = 16'h6F91;
`else
    localparam logic [63:0] FX32 = 64'h0;
    localparam logic [31:0] E32  = 32'h0376E6E7;
    localparam logic [15:0] E16  = 16'h29B1;
`endif

    logic        clk = 0, rst = 0;
    logic        in_valid = 0, in_last = 0, crc_ready = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready32, crc_valid32, in_ready16, crc_valid16;
    logic [31:0] crc_out32;
    logic [15:0] crc_out16;
    logic [7:0]  msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    crc_parallel #(.CRC_SIZE(32), .DATA_W(8), .INIT(64'hFFFFFFFF), .POLY(64'h04C11DB7),
                   .FINAL_XOR(FX32)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data),
        .in_last(in_last), .crc_valid(crc_valid32), .crc_ready(crc_ready), .crc_out(crc_out32));

    crc_parallel #(.CRC_SIZE(16), .DATA_W(8), .INIT(64'hFFFF), .POLY(64'h1021),
                   .FINAL_XOR(64'h0)) d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .in_last(in_last), .crc_valid(crc_valid16), .crc_ready(crc_ready), .crc_out(crc_out16));

    // Drives msg[first .. first+count-1] one beat per accepted clock, optional idle gaps.
    task automatic send_beats(input int first, input int count, input bit gaps);
        for (int i = first; i < first + count; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 0;
                in_data  = 8'hA5;
                in_last  = 1;
                @(negedge clk);
            end
            in_valid = 1;
            in_data  = msg[i];
            in_last  = (i == 8);
            @(negedge clk);
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic test_reset();
        checks += 4;
        if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32); end
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL reset_crc_valid: got %b expected 0", crc_valid32); end
        if (crc_out32 !== 32'h0) begin errors++; $display("FAIL reset_crc_out32: got %h expected 0", crc_out32); end
        if (crc_out16 !== 16'h0) begin errors++; $display("FAIL reset_crc_out16: got %h expected 0", crc_out16); end
    endtask

    task automatic test_frame();
        send_beats(0, 8, 0);
        checks++;
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL frame_early_valid: got %b expected 0", crc_valid32); end
        send_beats(8, 1, 0);
        checks += 5;
        if (crc_valid32 !== 1'b1) begin errors++; $display("FAIL frame_latency_valid: got %b expected 1", crc_valid32); end
        if (crc_valid16 !== 1'b1) begin errors++; $display("FAIL frame_valid16: got %b expected 1", crc_valid16); end
        if (crc_out32 !== E32) begin errors++; $display("FAIL frame_crc32: got %h expected %h", crc_out32, E32); end
        if (crc_out16 !== E16) begin errors++; $display("FAIL frame_crc16: got %h expected %h", crc_out16, E16); end
        if (in_ready32 !== 1'b0) begin errors++; $display("FAIL frame_done_ready: got %b expected 0", in_ready32); end
        crc_ready = 1;
        @(negedge clk);
        crc_ready = 0;
        checks += 3;
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL handoff_valid: got %b expected 0", crc_valid32); end
        if (crc_out32 !== 32'h0) begin errors++; $display("FAIL handoff_clear: got %h expected 0", crc_out32); end
        if (in_ready32 !== 1'b1) begin errors++; $display("FAIL handoff_ready: got %b expected 1", in_ready32); end
    endtask

    task automatic test_backpressure();
        send_beats(0, 9, 0);
        in_valid = 1;
        in_data  = msg[0];
        repeat (10) begin
            @(negedge clk);
            checks += 3;
            if (in_ready32 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready32); end
            if (crc_valid32 !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", crc_valid32); end
            if (crc_out32 !== E32) begin errors++; $display("FAIL bp_stable: got %h expected %h", crc_out32, E32); end
        end
        crc_ready = 1;
        @(negedge clk);
        crc_ready = 0;
        checks += 2;
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", crc_valid32); end
        if (in_ready32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready32); end
        send_beats(0, 9, 0);
        checks += 2;
        if (crc_out32 !== E32) begin errors++; $display("FAIL bp_repeat_crc32: got %h expected %h", crc_out32, E32); end
        if (crc_out16 !== E16) begin errors++; $display("FAIL bp_repeat_crc16: got %h expected %h", crc_out16, E16); end
        crc_ready = 1;
        @(negedge clk);
        crc_ready = 0;
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            send_beats(0, 9, 1);
            checks += 2;
            if (crc_out32 !== E32) begin errors++; $display("FAIL gaps_crc32 run %0d: got %h expected %h", r, crc_out32, E32); end
            if (crc_out16 !== E16) begin errors++; $display("FAIL gaps_crc16 run %0d: got %h expected %h", r, crc_out16, E16); end
            crc_ready = 1;
            @(negedge clk);
            crc_ready = 0;
        end
    endtask

    task automatic test_mid_reset();
        send_beats(0, 4, 0);
        rst = 0;
        #1;
        checks += 3;
        if (in_ready32 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready32); end
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", crc_valid32); end
        if (crc_out32 !== 32'h0) begin errors++; $display("FAIL midrst_out: got %h expected 0", crc_out32); end
        @(negedge clk);
        rst = 1;
        send_beats(0, 9, 0);
        checks += 2;
        if (crc_out32 !== E32) begin errors++; $display("FAIL midrst_crc32: got %h expected %h", crc_out32, E32); end
        if (crc_out16 !== E16) begin errors++; $display("FAIL midrst_crc16: got %h expected %h", crc_out16, E16); end
        rst = 0;
        #1;
        checks += 3;
        if (crc_valid32 !== 1'b0) begin errors++; $display("FAIL donerst_valid: got %b expected 0", crc_valid32); end
        if (crc_out32 !== 32'h0) begin errors++; $display("FAIL donerst_out: got %h expected 0", crc_out32); end
        if (in_ready32 !== 1'b1) begin errors++; $display("FAIL donerst_ready: got %b expected 1", in_ready32); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1;
        @(negedge clk);
        test_frame();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
